xts_tweak_gen: RTL

//  Generates the per-block XTS tweak stream T_j = E_K2(IV) * alpha^j over GF(2^128), j = 0..N-1.

---
 rtl/xts_tweak_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/xts_tweak_gen.sv
// xts_tweak_gen: turns the encrypted sector tweak E_K2(IV) into the per-block
// XTS tweak stream T_j = E_K2(IV) * alpha^j over GF(2^128). It hands the stream
// to the whitening XOR stage one tweak per accepted valid/ready transfer.
module xts_tweak_gen #(
    parameter int COUNT_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_tweak_valid,
    input  logic [127:0]       i_tweak,
    input  logic [COUNT_W-1:0] i_num_blocks,
    output logic               o_load_ready,
    input  logic               i_abort,
    output logic [127:0]       o_tweak,
    output logic               o_tweak_valid,
    input  logic               i_tweak_ready,
    output logic [COUNT_W-1:0] o_block_idx,
    output logic               o_last,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [127:0]       tweak_q;
    logic [COUNT_W-1:0] idx_q;
    logic [COUNT_W-1:0] num_q;
    logic               valid_q;
    logic               transfer;
    logic               is_last;

    // Multiply by alpha. Byte 0 sits in the top byte of the vector and is the
    // least significant byte, so each bit of the shift carries from byte k-1
    // into byte k. The bit that falls out of byte 15 folds back in as 0x87.
    function automatic logic [127:0] mul_alpha(input logic [127:0] t);
        logic [127:0] r;
        logic         carry;
        carry = t[7];
        r     = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 7] = t[126-8*k -: 7];
            if (k == 0)
                r[120] = 1'b0;
            else
                r[120-8*k] = t[135-8*k];
        end
        if (carry)
            r[127:120] = r[127:120] ^ 8'h87;
        return r;
    endfunction

    assign transfer      = valid_q & i_tweak_ready;
    assign is_last       = (idx_q == (num_q - 1'b1));
    assign o_tweak       = tweak_q;
    assign o_tweak_valid = valid_q;
    assign o_block_idx   = idx_q;
    assign o_last        = valid_q & is_last;
    assign o_load_ready  = (state == IDLE);
    assign o_done        = (state == DONE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic. Abort overrides every other event.
    always_comb begin
        state_next = state;
        if (i_abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (i_tweak_valid)
                          state_next = (i_num_blocks == '0) ? DONE : RUN;
                RUN:  if (transfer && is_last)
                          state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Tweak, index and valid registers: load, advance on transfer, clear on abort.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tweak_q <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else if (i_abort) begin
            tweak_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_tweak_valid) begin
                        tweak_q <= i_tweak;
                        num_q   <= i_num_blocks;
                        idx_q   <= '0;
                        valid_q <= (i_num_blocks != '0);
                    end
                end
                RUN: begin
                    if (transfer) begin
                        if (is_last) begin
                            valid_q <= 1'b0;
                        end else begin
                            tweak_q <= mul_alpha(tweak_q);
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
